// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthru bus monitors.
package i2c_passthru_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int unsigned I2C_BITS_PER_BYTE   = 8;
  localparam int unsigned I2C_TIMEOUT_CYC_DEF = 200000;

endpackage

// File: rtl/i2c_passthru_edge_det.sv
// Registers the filtered SDA/SCL pair and decodes SCL edges and START/STOP conditions.
module i2c_passthru_edge_det (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_sda,
  input  logic i_scl,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic r_sda_d;
  logic r_scl_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sda_d <= 1'b1;
      r_scl_d <= 1'b1;
    end else begin
      r_sda_d <= i_sda;
      r_scl_d <= i_scl;
    end
  end

  // START/STOP need SCL high in both cycles, so a simultaneous SCL edge never qualifies.
  always_comb begin
    o_scl_rise  = i_scl & ~r_scl_d;
    o_scl_fall  = ~i_scl & r_scl_d;
    o_start_det = r_scl_d & i_scl & r_sda_d & ~i_sda;
    o_stop_det  = r_scl_d & i_scl & ~r_sda_d & i_sda;
  end

endmodule

// File: rtl/i2c_passthru_bus_monitor.sv
// Observes the filtered I2C bus and decodes START/rSTART/STOP, bytes, ACK/NACK and SCL-low timeouts.
module i2c_passthru_bus_monitor
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = I2C_TIMEOUT_CYC_DEF,
  parameter int unsigned TO_W        = 18
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_start,
  output logic       o_rstart,
  output logic       o_stop,
  output logic       o_busy,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_addr_byte,
  output logic       o_rw,
  output logic       o_ack_vld,
  output logic       o_nack,
  output logic       o_timeout
);

  localparam logic [3:0]      LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_scl_rise;
  logic            w_scl_fall_unused;
  logic            w_start_det;
  logic            w_stop_det;
  logic            w_to_fire;
  logic            w_byte_done;
  logic            w_ack_done;
  logic            w_rstart;
  logic [3:0]      r_bit_cnt;
  logic [6:0]      r_shreg;
  logic            r_addr;
  logic [TO_W-1:0] r_to_cnt;

  logic       r_start, r_rstart, r_stop, r_busy, r_byte_vld;
  logic       r_addr_byte, r_rw, r_ack_vld, r_nack, r_timeout;
  logic [7:0] r_byte;

  i2c_passthru_edge_det u_edge_det (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_sda       (i_sda),
    .i_scl       (i_scl),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall_unused),
    .o_start_det (w_start_det),
    .o_stop_det  (w_stop_det)
  );

  // START/STOP need SCL high, timeout needs SCL low, so these never coincide with a bit sample.
  always_comb begin
    w_to_fire   = r_busy & ~i_scl & (r_to_cnt == TO_LAST);
    w_byte_done = (r_state == ST_DATA) & w_scl_rise & (r_bit_cnt == LAST_BIT);
    w_ack_done  = (r_state == ST_ACK) & w_scl_rise;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start_det)                   w_state_nxt = ST_DATA;
    else if (w_stop_det || w_to_fire)  w_state_nxt = ST_IDLE;
    else if (w_byte_done)              w_state_nxt = ST_ACK;
    else if (w_ack_done)               w_state_nxt = ST_DATA;
  end

  always_comb begin
    w_rstart = w_start_det & (r_state != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_start    <= 1'b0;
      r_rstart   <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
      r_byte_vld <= 1'b0;
      r_ack_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_start    <= w_start_det;
      r_rstart   <= w_rstart;
      r_stop     <= w_stop_det;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_byte_vld <= w_byte_done;
      r_ack_vld  <= w_ack_done;
      r_timeout  <= w_to_fire;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_addr      <= 1'b0;
      r_byte      <= '0;
      r_addr_byte <= 1'b0;
      r_rw        <= 1'b0;
      r_nack      <= 1'b0;
    end else if (w_start_det) begin
      r_bit_cnt <= '0;
      r_addr    <= 1'b1;
    end else if (w_stop_det || w_to_fire) begin
      r_bit_cnt <= '0;
    end else if ((r_state == ST_DATA) && w_scl_rise) begin
      r_shreg   <= {r_shreg[5:0], i_sda};
      r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_byte_done) begin
        r_byte      <= {r_shreg, i_sda};
        r_addr_byte <= r_addr;
        if (r_addr) r_rw <= i_sda;
      end
    end else if (w_ack_done) begin
      r_nack    <= i_sda;
      r_addr    <= 1'b0;
      r_bit_cnt <= '0;
    end
  end

  // Saturating counter of consecutive SCL-low cycles while the bus is busy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                            r_to_cnt <= '0;
    else if (i_scl || !r_busy || w_to_fire) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST)           r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign o_start     = r_start;
  assign o_rstart    = r_rstart;
  assign o_stop      = r_stop;
  assign o_busy      = r_busy;
  assign o_byte      = r_byte;
  assign o_byte_vld  = r_byte_vld;
  assign o_addr_byte = r_addr_byte;
  assign o_rw        = r_rw;
  assign o_ack_vld   = r_ack_vld;
  assign o_nack      = r_nack;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_i2c_passthru_bus_monitor.sv
// Bench for the I2C bus monitor: bit-level bus driver, event-level reference model and scoreboard.
module tb_i2c_passthru_bus_monitor;

  localparam int unsigned TO_CYC = 100;

  logic       clk = 1'b0;
  logic       rstn, sda, scl;
  logic       o_start, o_rstart, o_stop, o_busy, o_byte_vld, o_addr_byte;
  logic       o_rw, o_ack_vld, o_nack, o_timeout;
  logic [7:0] o_byte;

  i2c_passthru_bus_monitor #(.TIMEOUT_CYC(TO_CYC), .TO_W(7)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_sda(sda), .i_scl(scl),
    .o_start(o_start), .o_rstart(o_rstart), .o_stop(o_stop), .o_busy(o_busy),
    .o_byte(o_byte), .o_byte_vld(o_byte_vld), .o_addr_byte(o_addr_byte), .o_rw(o_rw),
    .o_ack_vld(o_ack_vld), .o_nack(o_nack), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int act_q[$];

  // Reference model state: transaction-level view of the bus.
  bit m_busy, m_first, m_rw, m_nack;
  int m_pos, m_acc, m_last_byte;

  localparam int EV_START = 1, EV_STOP = 2, EV_BYTE = 3, EV_ACK = 4, EV_TO = 5;

  function automatic int ev(input int kind, input int data, input int f1, input int f2);
    return kind * 4096 + data * 16 + f1 * 2 + f2;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (o_start)    act_q.push_back(ev(EV_START, 0, int'(o_rstart), 0));
      if (o_stop)     act_q.push_back(ev(EV_STOP, 0, 0, 0));
      if (o_byte_vld) act_q.push_back(ev(EV_BYTE, int'(o_byte), int'(o_addr_byte), int'(o_rw)));
      if (o_ack_vld)  act_q.push_back(ev(EV_ACK, 0, int'(o_nack), 0));
      if (o_timeout)  act_q.push_back(ev(EV_TO, 0, 0, 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_start();
    exp_q.push_back(ev(EV_START, 0, int'(m_busy), 0));
    m_busy = 1; m_first = 1; m_pos = 0; m_acc = 0;
  endtask

  task automatic model_stop();
    exp_q.push_back(ev(EV_STOP, 0, 0, 0));
    m_busy = 0; m_pos = 0; m_acc = 0;
  endtask

  task automatic model_bit(input bit b);
    if (!m_busy) return;
    if (m_pos < 8) begin
      m_acc = m_acc * 2 + int'(b);
      m_pos++;
      if (m_pos == 8) begin
        if (m_first) m_rw = b;
        m_last_byte = m_acc;
        exp_q.push_back(ev(EV_BYTE, m_acc, int'(m_first), int'(m_rw)));
      end
    end else begin
      m_nack = b;
      exp_q.push_back(ev(EV_ACK, 0, int'(b), 0));
      m_pos = 0; m_acc = 0; m_first = 0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_rw = 0; m_nack = 0;
    m_pos = 0; m_acc = 0; m_last_byte = 0;
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda = 1'b1; tick(2);
      scl = 1'b1; tick(2);
    end
    sda = 1'b0; tick(2);
    scl = 1'b0; tick(2);
    model_start();
  endtask

  task automatic bus_stop();
    sda = 1'b0; tick(2);
    scl = 1'b1; tick(2);
    sda = 1'b1; tick(2);
    model_stop();
  endtask

  task automatic send_bit(input bit b);
    sda = b;    tick(2);
    scl = 1'b1; tick(2);
    scl = 1'b0; tick(1);
    model_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // SDA changes in the same cycle as both SCL edges.
  task automatic fast_bit(input bit b);
    sda = b;  scl = 1'b1; tick(2);
    sda = ~b; scl = 1'b0; tick(2);
    model_bit(b);
  endtask

  task automatic sb_flush(input string tag);
    tick(3);
    chk({tag, "_nev"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({tag, "_ev"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
    chk({tag, "_busy"}, int'(o_busy), int'(m_busy));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] v;
    model_reset();
    rstn = 1'b0; sda = 1'b1; scl = 1'b1;
    tick(3);
    chk("reset_outputs", int'({o_start, o_rstart, o_stop, o_busy, o_byte_vld, o_addr_byte,
                                o_rw, o_ack_vld, o_nack, o_timeout, o_byte}), 0);
    rstn = 1'b1;
    tick(2);

    // 1: address read byte with ACK
    bus_start();
    chk("t1_busy", int'(o_busy), 1);
    send_byte(8'hA1); send_bit(1'b0); bus_stop();
    sb_flush("t1");
    chk("t1_byte_hold", int'(o_byte), 'hA1);
    chk("t1_rw", int'(o_rw), 1);

    // 2: address write, data byte, NACK
    bus_start();
    send_byte(8'h50); send_bit(1'b0);
    send_byte(8'h3C); send_bit(1'b1);
    bus_stop();
    sb_flush("t2");
    chk("t2_nack_hold", int'(o_nack), 1);
    chk("t2_rw", int'(o_rw), 0);

    // 3: repeated START drops a partial byte
    bus_start();
    send_byte(8'hA0); send_bit(1'b0);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    bus_start();
    send_byte(8'hA1); send_bit(1'b0);
    bus_stop();
    sb_flush("t3");
    chk("t3_rw", int'(o_rw), 1);

    // 4: SCL stuck low after START
    sda = 1'b0; tick(2);
    model_start();
    scl = 1'b0;
    n = 0;
    while (n < 300 && !o_timeout) begin
      @(negedge clk);
      n++;
    end
    chk("t4_to_cycle", n, TO_CYC);
    exp_q.push_back(ev(EV_TO, 0, 0, 0));
    m_busy = 0; m_pos = 0; m_acc = 0;
    tick(1);
    chk("t4_busy", int'(o_busy), 0);
    sb_flush("t4");
    bus_stop();
    sb_flush("t4_idle_stop");
    chk("t4_byte_hold", int'(o_byte), m_last_byte);

    // 5: simultaneous SDA/SCL changes
    sda = 1'b0; scl = 1'b0; tick(2);
    sda = 1'b1; scl = 1'b1; tick(2);
    sda = 1'b0; scl = 1'b0; tick(2);
    sda = 1'b1; scl = 1'b1; tick(2);
    sb_flush("t5_idle");
    bus_start();
    v = 8'h96;
    for (int i = 7; i >= 0; i--) fast_bit(v[i]);
    fast_bit(1'b1);
    bus_stop();
    sb_flush("t5_fast");

    // 6: asynchronous reset during bit 5
    bus_start();
    send_byte(8'hA1); send_bit(1'b0);
    sb_flush("t6_pre");
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_clear", int'({o_busy, o_rw, o_nack, o_addr_byte, o_byte}), 0);
    model_reset();
    act_q.delete();
    tick(2);
    rstn = 1'b1;
    scl = 1'b0; tick(2);
    send_byte(8'hFF); send_bit(1'b0);
    sb_flush("t6_post");

    // random traffic, with occasional mid-byte rSTART or STOP
    for (int t = 0; t < 30; t++) begin
      bus_start();
      for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 1) begin
          for (int k = 0; k < int'($urandom_range(1, 7)); k++) send_bit(1'($urandom));
          if (r == 1) bus_stop();
          bus_start();
        end else begin
          send_byte(8'($urandom));
          send_bit(1'($urandom));
        end
      end
      bus_stop();
      sb_flush($sformatf("rnd%0d", t));
      chk("rnd_byte_hold", int'(o_byte), m_last_byte);
      chk("rnd_rw_hold", int'(o_rw), int'(m_rw));
      chk("rnd_nack_hold", int'(o_nack), int'(m_nack));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
